// File: rtl/ultra_net_mac_pipe.sv
// ultra_net_mac_pipe: pipelined unsigned-activation x signed-weight MAC with group accumulation.
// Latency: an accepted first&last beat shows on out_valid NUM_STAGE+1 cycles after acceptance; 1 beat/cycle.
// Backpressure: out_valid && !out_ready freezes every stage, the accumulator and the result; in_ready drops.
//
// Optional feature macro: ULTRA_NET_MAC_SAT_EN
//   defined   -> out_acc is OUT_W wide, clamped at emission, out_sat flags clamping
//   undefined -> out_acc is the full ACC_W sum, no out_sat port
//
// Ports:
//   ap_clk, ap_rst                 clock, synchronous active-high reset
//   in_valid/in_ready              input beat handshake
//   in_a, in_b                     unsigned activation, signed weight
//   in_first, in_last              group delimiters carried with the beat
//   out_valid/out_ready            result handshake
//   out_acc (, out_sat)            signed group sum (and saturation flag)
module ultra_net_mac_pipe #(
  parameter int A_W       = 12,
  parameter int B_W       = 18,
  parameter int ACC_W     = 40,
  parameter int NUM_STAGE = 3,
  parameter int OUT_W     = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [A_W-1:0]          in_a,
  input  logic signed [B_W-1:0]   in_b,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef ULTRA_NET_MAC_SAT_EN
  output logic signed [OUT_W-1:0] out_acc,
  output logic                    out_sat
`else
  output logic signed [ACC_W-1:0] out_acc
`endif
);

  localparam int P_W = A_W + B_W;
`ifdef ULTRA_NET_MAC_SAT_EN
  localparam int RES_W = OUT_W;
`else
  localparam int RES_W = ACC_W;
`endif

  // Elaboration-time guard on the legal parameter space.
  localparam bit CFG_OK = (ACC_W >= P_W) && (OUT_W <= ACC_W) && (OUT_W >= 2) &&
                          (NUM_STAGE >= 1) && (NUM_STAGE <= 6);
  if (!CFG_OK) begin : g_bad_cfg
    $error("ultra_net_mac_pipe: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // Handshake / stall
  // ---------------------------------------------------------------------------
  logic out_valid_q, out_valid_d;
  logic stall;
  logic take;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !ap_rst && !stall;
  assign take     = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Multiplier pipeline
  // ---------------------------------------------------------------------------
  // Operands are widened to P_W before the multiply so the product is exact:
  // activation zero-extended, weight sign-extended.
  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;
  logic signed [P_W-1:0] prod_in;

  assign a_ext   = {{B_W{1'b0}}, in_a};
  assign b_ext   = {{A_W{in_b[B_W-1]}}, in_b};
  assign prod_in = a_ext * b_ext;

  // The product is formed into stage 0 and carried through the remaining
  // stages so downstream tools can retime the multiplier across them.
  logic signed [P_W-1:0] p_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]  vld_q;
  logic [NUM_STAGE-1:0]  first_q;
  logic [NUM_STAGE-1:0]  last_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (!stall) begin
      vld_q[0]   <= take;
      // Bubbles carry clean tags so a stray first/last never leaks forward.
      first_q[0] <= take && in_first;
      last_q[0]  <= take && in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_q[i]   <= vld_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  // Product data needs no reset: it is only consumed alongside a valid bit.
  always_ff @(posedge ap_clk) begin
    if (!stall) begin
      p_q[0] <= prod_in;
      for (int i = 1; i < NUM_STAGE; i++) begin
        p_q[i] <= p_q[i-1];
      end
    end
  end

  logic                    fin_vld;
  logic                    fin_first;
  logic                    fin_last;
  logic signed [ACC_W-1:0] p_ext;

  assign fin_vld   = vld_q[NUM_STAGE-1];
  assign fin_first = first_q[NUM_STAGE-1];
  assign fin_last  = last_q[NUM_STAGE-1];
  assign p_ext     = ACC_W'(p_q[NUM_STAGE-1]);

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc_q, acc_d;
  // Set once the last accumulated beat closed its group: the next beat restarts
  // the sum even without a first tag.
  logic                    grp_done_q, grp_done_d;

  always_comb begin
    acc_d      = acc_q;
    grp_done_d = grp_done_q;
    if (!stall && fin_vld) begin
      if (fin_first || grp_done_q) begin
        acc_d = p_ext;
      end else begin
        acc_d = acc_q + p_ext;
      end
      grp_done_d = fin_last;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_q      <= '0;
      grp_done_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      grp_done_q <= grp_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result formatting
  // ---------------------------------------------------------------------------
  logic signed [RES_W-1:0] res_val;
  logic                    res_sat;

`ifdef ULTRA_NET_MAC_SAT_EN
  // The sum fits OUT_W exactly when all bits from the OUT_W sign bit upward agree.
  logic [ACC_W-OUT_W:0] acc_hi;
  assign acc_hi  = acc_d[ACC_W-1:OUT_W-1];
  assign res_sat = !((&acc_hi) || !(|acc_hi));
  assign res_val = !res_sat         ? acc_d[OUT_W-1:0] :
                   acc_d[ACC_W-1]   ? {1'b1, {(OUT_W-1){1'b0}}} :
                                      {1'b0, {(OUT_W-1){1'b1}}};
`else
  assign res_val = acc_d;
  assign res_sat = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic signed [RES_W-1:0] out_acc_q, out_acc_d;
  logic                    out_sat_q, out_sat_d;

  // When not stalled the current result is either absent or being taken this
  // cycle, so a new group result may load over it with out_valid staying high.
  always_comb begin
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_sat_d   = out_sat_q;
    if (!stall) begin
      if (fin_vld && fin_last) begin
        out_valid_d = 1'b1;
        out_acc_d   = res_val;
        out_sat_d   = res_sat;
      end else begin
        out_valid_d = 1'b0;
        out_sat_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
`ifdef ULTRA_NET_MAC_SAT_EN
  assign out_sat   = out_sat_q;
`else
  // Saturation never happens at full width; keep the net tied off.
  logic unused_sat;
  assign unused_sat = out_sat_q ^ res_sat;
`endif

endmodule

// File: tb/tb_ultra_net_mac_pipe.sv
// tb_ultra_net_mac_pipe: directed, table-driven bench for ultra_net_mac_pipe.
// Latency: results are logged at the negedge of each output handshake cycle.
// Backpressure: out_ready is toggled by hand-written sequences.
module tb_ultra_net_mac_pipe;

`ifdef ULTRA_NET_MAC_SAT_EN
  localparam int OW = 16;
  localparam int RW = 16;
`else
  localparam int OW = 32;
  localparam int RW = 40;
`endif

  logic                 ap_clk = 1'b0;
  logic                 ap_rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [11:0]          in_a = '0;
  logic signed [17:0]   in_b = '0;
  logic                 in_first = 1'b0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [RW-1:0] out_acc;
  logic                 out_sat_w;

  ultra_net_mac_pipe #(
    .A_W(12), .B_W(18), .ACC_W(40), .NUM_STAGE(3), .OUT_W(OW)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_first (in_first),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef ULTRA_NET_MAC_SAT_EN
    .out_acc  (out_acc),
    .out_sat  (out_sat_w)
`else
    .out_acc  (out_acc)
`endif
  );

`ifndef ULTRA_NET_MAC_SAT_EN
  assign out_sat_w = 1'b0;
`endif

  always #5 ap_clk = ~ap_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Result log: one entry per output handshake.
  longint res_q[$];
  int     rcyc_q[$];
  bit     rsat_q[$];

  always @(negedge ap_clk) begin
    if (!ap_rst && out_valid && out_ready) begin
      res_q.push_back(longint'(out_acc));
      rcyc_q.push_back(cyc);
      rsat_q.push_back(out_sat_w);
    end
  end

  typedef struct {
    int     a;
    int     b;
    bit     first;
    bit     last;
    longint exp;   // expected group sum, meaningful on last beats only
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint model_res(input longint v);
`ifdef ULTRA_NET_MAC_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
`endif
    return v;
  endfunction

  function automatic bit model_sat(input longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  // Presents one beat and holds it until accepted; returns just after the accepting edge.
  task automatic send(input int a, input int b, input bit f, input bit l);
    bit ok;
    ok       = 1'b0;
    in_a     = a[11:0];
    in_b     = b[17:0];
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge ap_clk);
      ok = in_ready;
      if (ok) acc_cyc = cyc;
      @(posedge ap_clk);
      #1;
    end
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout: beat a=%0d b=%0d never accepted", a, b);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_res(input int n, input int budget);
    for (int k = 0; k < budget && res_q.size() < n; k++) begin
      @(posedge ap_clk);
      #1;
    end
    chk("result_count", res_q.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nexp;
    int idx;

    tbl[0]  = '{3, 5, 1'b1, 1'b0, 0};
    tbl[1]  = '{2, -7, 1'b0, 1'b0, 0};
    tbl[2]  = '{10, 1, 1'b0, 1'b1, 11};
    tbl[3]  = '{4, 4, 1'b0, 1'b1, 16};               // implicit first after a closed group
    tbl[4]  = '{100, 100, 1'b1, 1'b0, 0};
    tbl[5]  = '{6, 7, 1'b1, 1'b1, 42};               // mid-group first drops 10000
    tbl[6]  = '{0, -131072, 1'b1, 1'b1, 0};
    tbl[7]  = '{4095, 131071, 1'b1, 1'b1, 536735745};
    tbl[8]  = '{1, -1, 1'b1, 1'b0, 0};
    tbl[9]  = '{1, -1, 1'b0, 1'b1, -2};
    tbl[10] = '{4095, -131072, 1'b1, 1'b0, 0};
    tbl[11] = '{4095, -131072, 1'b0, 1'b1, -1073479680};

    // ---------------- reset state ----------------
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge ap_clk);
    #1;

    // ---------------- latency with extreme operands ----------------
    base = res_q.size();
    send(4095, -131072, 1'b1, 1'b1);
    idx = acc_cyc;
    idle(1);
    wait_res(base + 1, 50);
    if (res_q.size() > base) begin
      chk("extreme_value", res_q[base], model_res(-536739840));
      chk("extreme_latency", rcyc_q[base] - idx, 4);
    end

    // ---------------- table-driven groups, back-to-back ----------------
    base = res_q.size();
    nexp = 0;
    for (int k = 0; k < 12; k++) begin
      send(tbl[k].a, tbl[k].b, tbl[k].first, tbl[k].last);
      if (tbl[k].last) nexp++;
    end
    idle(1);
    wait_res(base + nexp, 100);
    idx = base;
    for (int k = 0; k < 12; k++) begin
      if (tbl[k].last && idx < res_q.size()) begin
        chk($sformatf("table_%0d", k), res_q[idx], model_res(tbl[k].exp));
`ifdef ULTRA_NET_MAC_SAT_EN
        chk($sformatf("table_sat_%0d", k), rsat_q[idx], model_sat(tbl[k].exp));
`endif
        idx++;
      end
    end

    // ---------------- throughput: 20 single-beat groups ----------------
    base = res_q.size();
    for (int i = 0; i < 20; i++) send(i, -1, 1'b1, 1'b1);
    idle(1);
    wait_res(base + 20, 100);
    for (int i = 0; i < 20 && base + i < res_q.size(); i++) begin
      chk($sformatf("thru_val_%0d", i), res_q[base + i], -i);
      if (i > 0) chk($sformatf("thru_gap_%0d", i), rcyc_q[base + i] - rcyc_q[base + i - 1], 1);
    end

    // ---------------- backpressure ----------------
    base = res_q.size();
    out_ready = 1'b0;
    fork
      begin
        send(1, 1, 1'b1, 1'b0);
        send(1, 1, 1'b0, 1'b1);
        send(2, 2, 1'b1, 1'b1);
        idle(3);
        send(3, 3, 1'b1, 1'b1);   // lands while the output is stalled
        idle(1);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
          @(negedge ap_clk);
          seen = out_valid;
        end
        chk("bp_result_arrives", seen, 1);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge ap_clk);
          chk($sformatf("bp_in_ready_%0d", k), in_ready, 0);
          chk($sformatf("bp_hold_acc_%0d", k), out_acc, 2);
          chk($sformatf("bp_hold_vld_%0d", k), out_valid, 1);
        end
        @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_res(base + 3, 100);
    idle(10);
    chk("bp_no_duplicates", res_q.size(), base + 3);
    if (res_q.size() >= base + 3) begin
      chk("bp_res0", res_q[base], 2);
      chk("bp_res1", res_q[base + 1], 4);
      chk("bp_res2", res_q[base + 2], 9);
    end

    // ---------------- reset mid-group ----------------
    base = res_q.size();
    send(7, 7, 1'b1, 1'b0);
    send(8, 8, 1'b0, 1'b0);
    in_valid = 1'b0;
    ap_rst   = 1'b1;
    @(negedge ap_clk);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    idle(10);
    chk("midrst_no_result", res_q.size(), base);
    chk("midrst_out_valid", out_valid, 0);
    send(5, 5, 1'b1, 1'b1);
    idle(1);
    wait_res(base + 1, 50);
    if (res_q.size() > base) chk("after_rst_group", res_q[base], 25);

`ifdef ULTRA_NET_MAC_SAT_EN
    // ---------------- saturation ----------------
    base = res_q.size();
    for (int i = 0; i < 1000; i++) send(4095, 1, i == 0, i == 999);
    idle(1);
    wait_res(base + 1, 50);
    if (res_q.size() > base) begin
      chk("sat_pos_val", res_q[base], 32767);
      chk("sat_pos_flag", rsat_q[base], 1);
    end
    send(7, -3, 1'b1, 1'b1);
    idle(1);
    wait_res(base + 2, 50);
    if (res_q.size() > base + 1) begin
      chk("sat_small_val", res_q[base + 1], -21);
      chk("sat_small_flag", rsat_q[base + 1], 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ultra_net_mac_pipe.md
Name: ultra_net_mac_pipe

Overview:
- Pipelined, parametrised multiply-accumulate unit for the UltraNet conv datapath.
- Computes unsigned activation × signed weight products through NUM_STAGE register stages, then accumulates them over a group delimited by first/last flags.
- Emits one accumulated result per group over a valid/ready handshake.
- Successor to the single-cycle combinational activation×weight multiplier: adds parametrised widths, pipeline depth, accumulation and backpressure.

Parameters:
- A_W, 12, activation width (unsigned)
- B_W, 18, weight width (signed, two's complement)
- ACC_W, 40, accumulator width (signed), must be ≥ A_W+B_W
- NUM_STAGE, 3, multiplier pipeline depth, legal range 1..6
- OUT_W, 32, output width when ULTRA_NET_MAC_SAT_EN is defined; must be ≤ ACC_W

Ports:
- ap_clk  in  1  clock; all state changes on rising edge
- ap_rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts a beat this cycle
- in_a  in  A_W  unsigned activation
- in_b  in  B_W  signed weight
- in_first  in  1  beat starts a new accumulation group
- in_last  in  1  beat ends the group
- out_valid  out  1  out_acc holds a group result
- out_ready  in  1  consumer accepts the result
- out_acc  out  ACC_W (OUT_W with SAT_EN)  signed group sum
- out_sat  out  1  present only with ULTRA_NET_MAC_SAT_EN

Behaviour:
- Product p = signed({1'b0,in_a}) × signed(in_b), width A_W+B_W, exact. Sign-extended to ACC_W before accumulation.
- Handshake and stall:
  - Beat accepted when in_valid && in_ready.
  - in_ready = !ap_rst && (!out_valid || out_ready).
  - Global stall: when out_valid && !out_ready, no pipeline stage, accumulator or tag advances, and out_acc holds.
- Pipeline:
  - Each stage carries p (partial or final), a valid bit, and the first/last tags. Bubbles propagate as valid=0.
  - The product is final at the output of stage NUM_STAGE. The accumulator register follows.
- Accumulate, on a valid final-stage beat when not stalled:
  - If tag first, or the previous accumulated beat was last: acc ← sext(p).
  - Otherwise acc ← acc + sext(p).
  - Arithmetic is modular two's complement at ACC_W bits (wraps, no flag).
- Emission:
  - If the beat carries last, next cycle out_valid=1 and out_acc = the new acc value.
  - out_valid and out_acc hold until out_valid && out_ready.
  - Result drop (out_valid cleared on handshake) and a new last result arriving in the same cycle: the new result loads with out_valid staying 1.
- Latency: accepted beat with first&last → out_valid exactly NUM_STAGE+1 cycles later. Throughput 1 beat/cycle with out_ready=1.
- Group boundaries:
  - A group of one beat (first&last) yields p.
  - A non-first beat following a completed group starts from 0 (implicit first).
  - first in mid-group discards the partial sum.
- Reset: ap_rst high clears all stage valid bits, tags, acc=0, out_valid=0, out_acc=0, out_sat=0, and forces in_ready=0. In-flight beats and partial sums are discarded; no result is emitted for them. in_ready=1 on the first cycle after ap_rst falls.

Optional Feature:
- Macro: ULTRA_NET_MAC_SAT_EN.
- Defined:
  - out_acc is OUT_W wide. At emission, the ACC_W sum is clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - out_sat=1 with that result iff clamping occurred; it holds/clears with out_valid.
  - Internal ACC_W accumulation is unchanged.
- Not defined: out_acc is the full ACC_W sum, the out_sat port does not exist, and there is no clamping logic.

Test Plan:
- Extremes: single beat a=4095, b=−131072, first=last=1 (defaults) → out_acc=−536739840 exactly NUM_STAGE+1=4 cycles after acceptance.
- Group sum: beats (3,5,first),(2,−7),(10,1,last) back-to-back → one result out_acc=11; out_valid pulses for 1 cycle with out_ready=1.
- Backpressure: out_ready=0 for 5 cycles during streaming of two groups {(1,1),(1,1)} and {(2,2)} → in_ready drops while out_valid high; results 2 then 4 are delivered in order, none lost or duplicated.
- Throughput: 20 single-beat groups a=i, b=−1 with continuous in_valid and out_ready=1 → 20 results −0..−19 on consecutive cycles.
- Reset mid-operation: assert ap_rst for 1 cycle after 2 beats of a 3-beat group → no result emitted. The following group (5,5,first&last) → 25.
- SAT_EN with OUT_W=16: 1000 beats a=4095, b=1 → out_acc=32767 with out_sat=1. A single beat a=7, b=−3 → −21 with out_sat=0.
